// File: rtl/reg_ctx_ctrl_pkg.sv
// Shared types for the register-context controller: bank FSM encoding and drain helpers.
package reg_ctx_ctrl_pkg;

   localparam int unsigned WORD_BITS_DEF     = 32;
   localparam int unsigned REG_ADDR_BITS_DEF = 5;
   localparam int unsigned DRAIN_CNT_BITS    = 4;

   typedef enum logic [1:0] {
      CTX_FRONT     = 2'd0,
      CTX_DRAIN_IN  = 2'd1,
      CTX_SHADOW    = 2'd2,
      CTX_DRAIN_OUT = 2'd3
   } ctxState_t;

   // A cycle counts toward the drain only when nothing is in flight anywhere near writeback.
   function automatic logic drainIdle(input logic pipeBusy, input logic aluValid,
                                      input logic ldValid, input logic dstValid);
      return !(pipeBusy | aluValid | ldValid | dstValid);
   endfunction

endpackage

// File: rtl/reg_ctx_ctrl_if.sv
// Writeback-to-register-file bus: two writeback sources in, one register-file write port out.
interface reg_ctx_ctrl_if #(
   parameter int unsigned WORD_BITS     = 32,
   parameter int unsigned REG_ADDR_BITS = 5
);

   logic                     iAluWbValid;
   logic [REG_ADDR_BITS-1:0] iAluWbAddr;
   logic [WORD_BITS-1:0]     iAluWbVal;
   logic                     iLdWbValid;
   logic [REG_ADDR_BITS-1:0] iLdWbAddr;
   logic [WORD_BITS-1:0]     iLdWbVal;
   logic                     oLdWbReady;
   logic [REG_ADDR_BITS-1:0] oDstAddr;
   logic [WORD_BITS-1:0]     oDstVal;
   logic                     oDstValid;

   modport master (
      output iAluWbValid, iAluWbAddr, iAluWbVal,
      output iLdWbValid, iLdWbAddr, iLdWbVal,
      input  oLdWbReady,
      input  oDstAddr, oDstVal, oDstValid
   );

   modport slave (
      input  iAluWbValid, iAluWbAddr, iAluWbVal,
      input  iLdWbValid, iLdWbAddr, iLdWbVal,
      output oLdWbReady,
      output oDstAddr, oDstVal, oDstValid
   );

endinterface

// File: rtl/reg_wb_arb.sv
// Fixed-priority write-port arbiter: ALU beats load, winner registered onto the file write port.
module reg_wb_arb #(
   parameter int unsigned WORD_BITS     = 32,
   parameter int unsigned REG_ADDR_BITS = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     iAluValid,
   input  logic [REG_ADDR_BITS-1:0] iAluAddr,
   input  logic [WORD_BITS-1:0]     iAluVal,
   input  logic                     iLdValid,
   input  logic [REG_ADDR_BITS-1:0] iLdAddr,
   input  logic [WORD_BITS-1:0]     iLdVal,
   output logic                     oLdReady,
   output logic [REG_ADDR_BITS-1:0] oDstAddr,
   output logic [WORD_BITS-1:0]     oDstVal,
   output logic                     oDstValid
);

   logic                     selValid;
   logic [REG_ADDR_BITS-1:0] selAddr;
   logic [WORD_BITS-1:0]     selVal;

   // The ALU has no backpressure, so a colliding load simply waits a cycle.
   assign oLdReady = iLdValid & ~iAluValid;

   always_comb begin
      selValid = 1'b0;
      selAddr  = '0;
      selVal   = '0;
      if (iAluValid) begin
         selValid = 1'b1;
         selAddr  = iAluAddr;
         selVal   = iAluVal;
      end else if (iLdValid) begin
         selValid = 1'b1;
         selAddr  = iLdAddr;
         selVal   = iLdVal;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oDstAddr  <= '0;
         oDstVal   <= '0;
         oDstValid <= 1'b0;
      end else begin
         // r0 is hard-wired zero: the write is consumed but never reaches the file.
         oDstValid <= selValid && (selAddr != '0);
         if (selValid) begin
            oDstAddr <= selAddr;
            oDstVal  <= selVal;
         end
      end
   end

endmodule

// File: rtl/reg_ctx_ctrl.sv
// Register-file context controller: write-port arbitration plus front/shadow bank switching.
// Optional status outputs (IRQ count, context error) are built when REG_CTX_STATUS_EN is defined.
module reg_ctx_ctrl
   import reg_ctx_ctrl_pkg::*;
#(
   parameter int unsigned WORD_BITS     = WORD_BITS_DEF,
   parameter int unsigned REG_ADDR_BITS = REG_ADDR_BITS_DEF,
   parameter int unsigned DRAIN_MIN     = 2
) (
   input  logic               clk,
   input  logic               rst,
   reg_ctx_ctrl_if.slave      wb,
   input  logic               iPipeBusy,
   input  logic               iIrqReq,
   input  logic               iEret,
   output logic               oShadowSwitch,
   output logic               oStall,
   output logic               oIrqAck,
   output logic               oEretAck
`ifdef REG_CTX_STATUS_EN
   ,
   output logic [7:0]         oIrqCount,
   output logic [0:0]         oCtxErr
`endif
);

   localparam logic [DRAIN_CNT_BITS-1:0] DRAIN_LAST = DRAIN_CNT_BITS'(DRAIN_MIN - 1);

   ctxState_t                 state;
   logic [DRAIN_CNT_BITS-1:0] drainCnt;
   logic                      idle;
   logic                      draining;
   logic                      drainDone;

   reg_wb_arb #(
      .WORD_BITS     (WORD_BITS),
      .REG_ADDR_BITS (REG_ADDR_BITS)
   ) uArb (
      .clk       (clk),
      .rst       (rst),
      .iAluValid (wb.iAluWbValid),
      .iAluAddr  (wb.iAluWbAddr),
      .iAluVal   (wb.iAluWbVal),
      .iLdValid  (wb.iLdWbValid),
      .iLdAddr   (wb.iLdWbAddr),
      .iLdVal    (wb.iLdWbVal),
      .oLdReady  (wb.oLdWbReady),
      .oDstAddr  (wb.oDstAddr),
      .oDstVal   (wb.oDstVal),
      .oDstValid (wb.oDstValid)
   );

   assign idle      = drainIdle(iPipeBusy, wb.iAluWbValid, wb.iLdWbValid, wb.oDstValid);
   assign draining  = (state == CTX_DRAIN_IN) || (state == CTX_DRAIN_OUT);
   // The edge that completes DRAIN_MIN idle cycles is the switch edge itself.
   assign drainDone = draining && idle && (drainCnt == DRAIN_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= CTX_FRONT;
         drainCnt      <= '0;
         oShadowSwitch <= 1'b0;
         oStall        <= 1'b0;
         oIrqAck       <= 1'b0;
         oEretAck      <= 1'b0;
      end else begin
         oIrqAck  <= 1'b0;
         oEretAck <= 1'b0;
         unique case (state)
            CTX_FRONT: begin
               if (iIrqReq) begin
                  state    <= CTX_DRAIN_IN;
                  oStall   <= 1'b1;
                  drainCnt <= '0;
               end
            end
            CTX_SHADOW: begin
               if (iEret) begin
                  state    <= CTX_DRAIN_OUT;
                  oStall   <= 1'b1;
                  drainCnt <= '0;
               end
            end
            CTX_DRAIN_IN, CTX_DRAIN_OUT: begin
               if (!idle) begin
                  drainCnt <= '0;
               end else if (drainDone) begin
                  drainCnt      <= '0;
                  oStall        <= 1'b0;
                  oShadowSwitch <= (state == CTX_DRAIN_IN);
                  if (state == CTX_DRAIN_IN) begin
                     state   <= CTX_SHADOW;
                     oIrqAck <= 1'b1;
                  end else begin
                     state    <= CTX_FRONT;
                     oEretAck <= 1'b1;
                  end
               end else begin
                  drainCnt <= drainCnt + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef REG_CTX_STATUS_EN
   logic enterShadow;

   assign enterShadow = drainDone && (state == CTX_DRAIN_IN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oIrqCount <= '0;
         oCtxErr   <= '0;
      end else begin
         if (enterShadow && (oIrqCount != 8'hFF)) begin
            oIrqCount <= oIrqCount + 8'd1;
         end
         // Sticky: a return with no context saved, or an attempted nested interrupt.
         if (((state == CTX_FRONT) && iEret) || ((state == CTX_SHADOW) && iIrqReq)) begin
            oCtxErr <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_reg_ctx_ctrl.sv
// Self-checking bench for reg_ctx_ctrl: vector table plus hand sequences, write scoreboard.
module tb_reg_ctx_ctrl;

   localparam int unsigned WB = 32;
   localparam int unsigned AB = 5;
   localparam int unsigned DM = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pipeBusy, irqReq, eret;
   logic shadowSwitch, stall, irqAck, eretAck;
`ifdef REG_CTX_STATUS_EN
   logic [7:0] irqCount;
   logic [0:0] ctxErr;
`endif

   always #5 clk = ~clk;

   reg_ctx_ctrl_if #(.WORD_BITS(WB), .REG_ADDR_BITS(AB)) bus ();

   reg_ctx_ctrl #(
      .WORD_BITS     (WB),
      .REG_ADDR_BITS (AB),
      .DRAIN_MIN     (DM)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wb            (bus),
      .iPipeBusy     (pipeBusy),
      .iIrqReq       (irqReq),
      .iEret         (eret),
      .oShadowSwitch (shadowSwitch),
      .oStall        (stall),
      .oIrqAck       (irqAck),
      .oEretAck      (eretAck)
`ifdef REG_CTX_STATUS_EN
      ,
      .oIrqCount     (irqCount),
      .oCtxErr       (ctxErr)
`endif
   );

   typedef struct {
      logic          aluV;
      logic [AB-1:0] aluA;
      logic [WB-1:0] aluD;
      logic          ldV;
      logic [AB-1:0] ldA;
      logic [WB-1:0] ldD;
      logic          busy;
      logic          irq;
      logic          er;
      logic          expReady;
      logic          expShadow;
      logic          expStall;
      logic          expIrqAck;
      logic          expEretAck;
   } vec_t;

   typedef struct {
      logic [AB-1:0] addr;
      logic [WB-1:0] val;
   } wr_t;

   int   checks = 0;
   int   errors = 0;
   wr_t  sbQ[$];
   vec_t tbl[16];

   function automatic vec_t mk(input logic aluV, input logic [AB-1:0] aluA,
                               input logic [WB-1:0] aluD, input logic ldV,
                               input logic [AB-1:0] ldA, input logic [WB-1:0] ldD,
                               input logic busy, input logic irq, input logic er,
                               input logic rdy, input logic sh, input logic st,
                               input logic ia, input logic ea);
      vec_t v;
      v.aluV = aluV; v.aluA = aluA; v.aluD = aluD;
      v.ldV = ldV; v.ldA = ldA; v.ldD = ldD;
      v.busy = busy; v.irq = irq; v.er = er;
      v.expReady = rdy; v.expShadow = sh; v.expStall = st;
      v.expIrqAck = ia; v.expEretAck = ea;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive, check the combinational ready, predict the write, clock, then compare.
   task automatic applyVec(input vec_t t, input string tag);
      wr_t w;
      bus.iAluWbValid = t.aluV; bus.iAluWbAddr = t.aluA; bus.iAluWbVal = t.aluD;
      bus.iLdWbValid  = t.ldV;  bus.iLdWbAddr  = t.ldA;  bus.iLdWbVal  = t.ldD;
      pipeBusy = t.busy; irqReq = t.irq; eret = t.er;
      #1;
      chk({tag, ".ready"}, bus.oLdWbReady, t.expReady);
      if (t.aluV) begin
         if (t.aluA != '0) begin
            w.addr = t.aluA; w.val = t.aluD; sbQ.push_back(w);
         end
      end else if (t.ldV) begin
         if (t.ldA != '0) begin
            w.addr = t.ldA; w.val = t.ldD; sbQ.push_back(w);
         end
      end
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
         w = sbQ.pop_front();
         chk({tag, ".dstValid"}, bus.oDstValid, 1'b1);
         chk({tag, ".dstAddr"}, bus.oDstAddr, w.addr);
         chk({tag, ".dstVal"}, bus.oDstVal, w.val);
      end else begin
         chk({tag, ".dstValid"}, bus.oDstValid, 1'b0);
      end
      chk({tag, ".shadow"}, shadowSwitch, t.expShadow);
      chk({tag, ".stall"}, stall, t.expStall);
      chk({tag, ".irqAck"}, irqAck, t.expIrqAck);
      chk({tag, ".eretAck"}, eretAck, t.expEretAck);
   endtask

   task automatic idleIn();
      bus.iAluWbValid = 1'b0; bus.iAluWbAddr = '0; bus.iAluWbVal = '0;
      bus.iLdWbValid  = 1'b0; bus.iLdWbAddr  = '0; bus.iLdWbVal  = '0;
      pipeBusy = 1'b0; irqReq = 1'b0; eret = 1'b0;
   endtask

   task automatic chkAllLow(input string tag);
      chk({tag, ".dstValid"}, bus.oDstValid, 1'b0);
      chk({tag, ".dstAddr"}, bus.oDstAddr, '0);
      chk({tag, ".dstVal"}, bus.oDstVal, '0);
      chk({tag, ".shadow"}, shadowSwitch, 1'b0);
      chk({tag, ".stall"}, stall, 1'b0);
      chk({tag, ".irqAck"}, irqAck, 1'b0);
      chk({tag, ".eretAck"}, eretAck, 1'b0);
`ifdef REG_CTX_STATUS_EN
      chk({tag, ".irqCount"}, irqCount, 8'd0);
      chk({tag, ".ctxErr"}, ctxErr, 1'b0);
`endif
   endtask

   initial begin
      // Arbitration, r0 handling, then an idle-pipe entry, ignored nested IRQ and return.
      tbl[0]  = mk(1, 3, 'h11, 1, 4, 'h22, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 'h00, 1, 4, 'h22, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 'h00, 1, 0, 'h33, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 'h44, 0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[4]  = mk(1, 7, 'h55, 1, 8, 'h66, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 'h00, 1, 8, 'h66, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1, 0, 0, 0, 1, 0, 0);
      tbl[8]  = mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 0, 1, 0, 0);
      tbl[9]  = mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 1, 0, 1, 0);
      tbl[10] = mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[11] = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1, 0, 0, 1, 0, 0, 0);
      tbl[12] = mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 1, 0, 1, 1, 0, 0);
      tbl[13] = mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 1, 0, 1, 1, 0, 0);
      tbl[14] = mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 1, 0, 0, 0, 0, 1);
      tbl[15] = mk(0, 0, 'h00, 0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0);

      idleIn();
      #2;
      chkAllLow("rst0");
      #10 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rstRel.shadow", shadowSwitch, 1'b0);

      for (int i = 0; i < 16; i++) applyVec(tbl[i], $sformatf("tbl%0d", i));
`ifdef REG_CTX_STATUS_EN
      chk("tbl.irqCount", irqCount, 8'd1);
      chk("tbl.ctxErr", ctxErr, 1'b1);
`endif

      // Busy drain: pipe busy for 5 cycles with a load landing in front bank, then a
      // mid-count ALU write that must restart the idle count.
      applyVec(mk(0, 0, 0, 0, 0, 0,     1, 1, 0, 0, 0, 1, 0, 0), "busy0");
      applyVec(mk(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 1, 0, 0), "busy1");
      applyVec(mk(0, 0, 0, 1, 9, 'hAB,  1, 0, 0, 1, 0, 1, 0, 0), "busy2");
      applyVec(mk(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 1, 0, 0), "busy3");
      applyVec(mk(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 1, 0, 0), "busy4");
      applyVec(mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 0), "busy5");
      applyVec(mk(1, 10, 'hCD, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "busy6");
      applyVec(mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 0), "busy7");
      applyVec(mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 0), "busy8");
      applyVec(mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 0, 1, 0), "busy9");
      applyVec(mk(0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 1, 1, 0, 0), "ret0");
      applyVec(mk(0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 1, 1, 0, 0), "ret1");
      applyVec(mk(0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 1), "ret2");
`ifdef REG_CTX_STATUS_EN
      chk("busy.irqCount", irqCount, 8'd2);
`endif

      // IRQ and ERET together in front: the IRQ wins.
      applyVec(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0), "both0");
      applyVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "both1");
      applyVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), "both2");
`ifdef REG_CTX_STATUS_EN
      chk("both.irqCount", irqCount, 8'd3);
`endif

      // Reset in the middle of a return drain drops straight back to the front bank.
      applyVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0), "rdrain0");
      #3;
      rst = 1'b1;
      eret = 1'b0;
      #1;
      chkAllLow("rstMid");
      sbQ.delete();
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      applyVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "frontEret");
      applyVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "frontIdle");
`ifdef REG_CTX_STATUS_EN
      chk("post.irqCount", irqCount, 8'd0);
      chk("post.ctxErr", ctxErr, 1'b1);
`endif
      chk("sb.empty", sbQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
